// File: rtl/fibre_a_server.sv
// rtl/fibre_a_server.sv - fibre_a spike-word store with ready/valid load port and fixed-latency reads
// Reads are bounds-checked against fill_count at issue; out-of-range returns 0 flagged by oob.
module fibre_a_server #(
  parameter int TIMESTEPS    = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [TIMESTEPS-1:0]  load_data,
  input  logic                  load_last,
  input  logic                  load_clear,
  input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
  input  logic                  fibre_a_read_en,
  output logic [TIMESTEPS-1:0]  fibre_a_data,
  output logic                  fibre_a_valid,
  output logic                  fibre_a_oob,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  loaded
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_SERVING = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
  logic                  load_fire;
  logic [ADDR_WIDTH:0]   fill_inc;

  logic [TIMESTEPS-1:0]  mem [DEPTH];

  logic                  rd_hit;
  logic [TIMESTEPS-1:0]  rd_data_d;
  logic                  rd_oob_d;

  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [READ_LATENCY-1:0] pipe_oob_q;
  logic [TIMESTEPS-1:0]    pipe_dat_q [READ_LATENCY];

  // Load side: flush has priority over a word offered in the same cycle.
  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    fill_inc     = fill_count_q + ONE_C;
    load_ready   = (state_q != S_SERVING) && (fill_count_q < DEPTH_C) && !load_clear;
    load_fire    = load_valid && load_ready;

    if (load_clear) begin
      state_d      = S_IDLE;
      fill_count_d = '0;
    end else if (load_fire) begin
      fill_count_d = fill_inc;
      if (load_last || (fill_inc == DEPTH_C)) begin
        state_d = S_SERVING;
      end else begin
        state_d = S_LOADING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by fill_count.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[fill_count_q[ADDR_WIDTH-1:0]] <= load_data;
    end
  end

  // Bounds use the pre-update fill_count, so a same-cycle write is never observed.
  always_comb begin
    rd_hit    = ({1'b0, fibre_a_addr} < fill_count_q);
    rd_data_d = '0;
    rd_oob_d  = 1'b1;
    if (rd_hit) begin
      rd_data_d = mem[fibre_a_addr];
      rd_oob_d  = 1'b0;
    end
  end

  // Data/oob stages only advance behind a valid, so the outputs hold their last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_oob_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= fibre_a_read_en;
      if (fibre_a_read_en) begin
        pipe_dat_q[0] <= rd_data_d;
        pipe_oob_q[0] <= rd_oob_d;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_dat_q[i] <= pipe_dat_q[i-1];
          pipe_oob_q[i] <= pipe_oob_q[i-1];
        end
      end
    end
  end

  assign fibre_a_valid = pipe_vld_q[READ_LATENCY-1];
  assign fibre_a_data  = pipe_dat_q[READ_LATENCY-1];
  assign fibre_a_oob   = pipe_oob_q[READ_LATENCY-1];
  assign fill_count    = fill_count_q;
  assign loaded        = (state_q == S_SERVING);

endmodule

// File: tb/tb_fibre_a_server.sv
// tb/tb_fibre_a_server.sv - scoreboard bench for fibre_a_server against a word-store reference model
module tb_fibre_a_server;

  localparam int TS  = 16;
  localparam int AW  = 8;
  localparam int DP  = 256;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [TS-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_clear = 1'b0;
  logic [AW-1:0] fibre_a_addr = '0;
  logic          fibre_a_read_en = 1'b0;
  logic [TS-1:0] fibre_a_data;
  logic          fibre_a_valid;
  logic          fibre_a_oob;
  logic [AW:0]   fill_count;
  logic          loaded;

  fibre_a_server #(.TIMESTEPS(TS), .ADDR_WIDTH(AW), .DEPTH(DP), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .load_clear(load_clear),
    .fibre_a_addr(fibre_a_addr), .fibre_a_read_en(fibre_a_read_en),
    .fibre_a_data(fibre_a_data), .fibre_a_valid(fibre_a_valid), .fibre_a_oob(fibre_a_oob),
    .fill_count(fill_count), .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TS-1:0] d;
    logic          o;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;

  // Reference model: a list of stored words plus a "fibre complete" flag.
  logic [TS-1:0] m_mem [DP];
  int            m_fill = 0;
  bit            m_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (fibre_a_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", 32'(fibre_a_data), 32'(e.d));
        chk("rd_oob", 32'(fibre_a_oob), 32'(e.o));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_valid: got no result expected one due at cycle %0d (cycle %0d)", sb[0].due, cyc);
      void'(sb.pop_front());
    end
  end

  task automatic step(input logic lv, input logic [TS-1:0] ld, input logic ll,
                      input logic lc, input logic re, input logic [AW-1:0] ra);
    bit   exp_ready;
    exp_t e;
    load_valid      = lv;
    load_data       = ld;
    load_last       = ll;
    load_clear      = lc;
    fibre_a_read_en = re;
    fibre_a_addr    = ra;
    #1;
    exp_ready = !m_full && (m_fill < DP) && !lc;
    chk("load_ready", 32'(load_ready), 32'(exp_ready));
    chk("fill_count", 32'(fill_count), 32'(m_fill));
    chk("loaded", 32'(loaded), 32'(m_full));
    if (re) begin
      if (int'(ra) < m_fill) begin
        e.d = m_mem[ra];
        e.o = 1'b0;
      end else begin
        e.d = '0;
        e.o = 1'b1;
      end
      e.due = cyc + RL;
      sb.push_back(e);
    end
    if (lc) begin
      m_fill = 0;
      m_full = 1'b0;
    end else if (lv && exp_ready) begin
      m_mem[m_fill] = ld;
      m_fill++;
      if (ll || m_fill == DP) m_full = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_valid"}, 32'(fibre_a_valid), 32'd0);
    chk({tag, "_data"}, 32'(fibre_a_data), 32'd0);
    chk({tag, "_oob"}, 32'(fibre_a_oob), 32'd0);
    chk({tag, "_fill"}, 32'(fill_count), 32'd0);
    chk({tag, "_loaded"}, 32'(loaded), 32'd0);
  endtask

  logic [TS-1:0] words [4];

  initial begin
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hA5A5; words[3] = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) step(1'b1, words[i], i == 3, 1'b0, 1'b0, '0);
    chk("fill_after_4", 32'(fill_count), 32'd4);
    chk("loaded_after_4", 32'(loaded), 32'd1);
    chk("ready_after_4", 32'(load_ready), 32'd0);

    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(i));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(4));
    idle(RL + 1);

    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("fill_after_clear", 32'(fill_count), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(1));
    idle(RL + 1);

    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, AW'(2));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(2));
    idle(RL + 1);

    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < DP; i++) step(1'b1, TS'($urandom), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, AW'(DP - 1));
    chk("fill_saturated", 32'(fill_count), 32'(DP));
    chk("loaded_at_depth", 32'(loaded), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(0));
    idle(RL + 1);

    for (int i = 0; i < 3000; i++) begin
      logic          lv, ll, lc, re;
      logic [AW-1:0] ra;
      lv = ($urandom_range(0, 3) != 0);
      ll = ($urandom_range(0, 40) == 0);
      lc = ($urandom_range(0, 60) == 0);
      re = ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, m_fill + 2));
      step(lv, TS'($urandom), ll, lc, re, ra);
    end
    idle(RL + 1);

    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(0));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(1));
    fibre_a_read_en = 1'b0;
    rst = 1'b1;
    sb.delete();
    m_fill = 0;
    m_full = 1'b0;
    #1;
    chk_reset_values("midread_reset");
    repeat (RL + 2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(RL + 2);
    chk_reset_values("after_reset");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
